// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types for branch resolution: FSM states, the per-stage tracking entry
// and the two-bit counter encodings used by the direction predictor.
package branch_pkg;

  localparam int unsigned PC_W = 32;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } br_state_e;

  typedef struct packed {
    logic            valid;
    logic            pred;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] fallthru;
  } br_entry_t;

  localparam br_entry_t BR_ENTRY_RST = '{
    valid:    1'b0,
    pred:     1'b0,
    pc:       '0,
    target:   '0,
    fallthru: '0
  };

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bp_cnt_e;

  function automatic bp_cnt_e bp_cnt_next(input bp_cnt_e cur, input logic take);
    bp_cnt_e nxt;
    nxt = cur;
    case (cur)
      CNT_SNT: nxt = take ? CNT_WNT : CNT_SNT;
      CNT_WNT: nxt = take ? CNT_WT  : CNT_SNT;
      CNT_WT:  nxt = take ? CNT_ST  : CNT_WNT;
      CNT_ST:  nxt = take ? CNT_ST  : CNT_WT;
      default: nxt = CNT_WNT;
    endcase
    return nxt;
  endfunction

  // Fetch PC the pipeline should have followed, given the resolved direction.
  function automatic logic [PC_W-1:0] redirect_target(input br_entry_t e, input logic take);
    return take ? e.target : e.fallthru;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_br_track_reg.sv
// One branch tracking entry (E or M stage). Priority: flush > hold > capture;
// a flush clears only the valid bit.
module br_track_reg
  import branch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      hold,
  input  br_entry_t d,
  output br_entry_t q
);

  br_entry_t entry_q;
  br_entry_t entry_d;

  always_comb begin
    entry_d = d;
    if (flush) begin
      entry_d       = entry_q;
      entry_d.valid = 1'b0;
    end else if (hold) begin
      entry_d = entry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= BR_ENTRY_RST;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Carries D-stage branch predictions through E and M, resolves them in M,
// updates the predictor and runs the mispredict flush/redirect handshake.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallE,
  input  logic             stallM,
  input  logic             flushE_ext,
  input  logic             branchD,
  input  logic             pred_takeD,
  input  logic [31:0]      pcD,
  input  logic [31:0]      targetD,
  input  logic [31:0]      fallthruD,
  input  logic             actual_takeM,
  input  logic             redirect_ready,
  output logic             upd_en,
  output logic [31:0]      upd_pc,
  output logic             upd_take,
  output logic             mispredM,
  output logic             flush_req,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  br_entry_t e_in;
  br_entry_t e_ent;
  br_entry_t m_in;
  br_entry_t m_ent;

  br_state_e        state_q;
  br_state_e        state_d;
  logic             redirect_valid_q;
  logic             redirect_valid_d;
  logic [31:0]      redirect_pc_q;
  logic [31:0]      redirect_pc_d;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_d;

  logic resolve_m;
  logic mispred_m;
  logic flush_all;
  logic e_flush;

  always_comb begin
    e_in          = BR_ENTRY_RST;
    e_in.valid    = branchD;
    e_in.pred     = pred_takeD;
    e_in.pc       = pcD;
    e_in.target   = targetD;
    e_in.fallthru = fallthruD;
  end

  // A stalled E feeding a moving M must not duplicate its branch into M.
  always_comb begin
    m_in = e_ent;
    if (stallE) begin
      m_in.valid = 1'b0;
    end
  end

  assign resolve_m = m_ent.valid & ~stallM & (state_q == RUN);
  assign mispred_m = resolve_m & (m_ent.pred != actual_takeM);
  assign flush_all = mispred_m | (state_q == RECOVER);
  assign e_flush   = flushE_ext | flush_all;

  br_track_reg u_track_e (
    .clk   (clk),
    .rst   (rst),
    .flush (e_flush),
    .hold  (stallE),
    .d     (e_in),
    .q     (e_ent)
  );

  // Clearing M on flush_all retires the mispredicted branch and keeps M empty
  // for the whole recovery, even if M is stalled.
  br_track_reg u_track_m (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_all),
    .hold  (stallM),
    .d     (m_in),
    .q     (m_ent)
  );

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      RUN: begin
        if (mispred_m) begin
          state_d          = RECOVER;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = redirect_target(m_ent, actual_takeM);
        end
      end
      RECOVER: begin
        if (redirect_ready) begin
          state_d          = RUN;
          redirect_valid_d = 1'b0;
        end
      end
      default: begin
        state_d          = RUN;
        redirect_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q + CNT_W'(resolve_m);
    mispred_cnt_d = mispred_cnt_q + CNT_W'(mispred_m);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign upd_en         = resolve_m;
  assign upd_pc         = m_ent.pc;
  assign upd_take       = actual_takeM;
  assign mispredM       = mispred_m;
  assign flush_req      = flush_all;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Controller that sequences the branch predictor across the pipeline. It carries each branch's D-stage prediction, target and fallthrough PC through E to M. At M it compares the prediction with the actual outcome and drives the predictor update strobe. On a mispredict it kills the younger stages and runs a redirect handshake with the PC/fetch unit. It sits between the decode/branch-predict logic, the M-stage branch unit and the PC generator, and keeps branch and mispredict counters.

Parameters:
CNT_W, 32, width of the statistics counters (wrap-around).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stallE  in  1  E stage stalled, tracking register E holds
stallM  in  1  M stage stalled, tracking register M holds
flushE_ext  in  1  external (non-branch) flush of E, e.g. load-use bubble
branchD  in  1  instruction in D is a branch
pred_takeD  in  1  predictor's decision for D branch
pcD  in  32  PC of D instruction
targetD  in  32  taken target computed in D
fallthruD  in  32  not-taken next PC (pcD+8, delay slot)
actual_takeM  in  1  resolved direction in M
redirect_ready  in  1  PC unit accepts redirect this cycle
upd_en  out  1  predictor update strobe (predictor branchM)
upd_pc  out  32  PC of resolving branch (predictor pcM)
upd_take  out  1  actual direction to predictor
mispredM  out  1  combinational mispredict indication
flush_req  out  1  kill D and E (to flushD/flushE)
redirect_valid  out  1  redirect request to PC unit
redirect_pc  out  32  corrected fetch PC
branch_cnt  out  CNT_W  resolved branches
mispred_cnt  out  CNT_W  mispredicted branches

Behaviour:
- Tracking entry {valid, pred, pc, target, fallthru}, one register each for E and M.
- E capture: when ~stallE, E <= D fields, valid = branchD. If flushE_ext or flush_req, E.valid <= 0. Flush wins over capture.
- M capture: when ~stallM, M <= E. If stallE & ~stallM, a bubble (valid=0) enters M. If stallM, M holds.
- Resolution: resolveM = M.valid & ~stallM & (state==RUN).
  - upd_en = resolveM. upd_pc = M.pc. upd_take = actual_takeM.
  - This is exactly one update per branch. A stalled M does not update until released.
- mispredM = resolveM & (M.pred != actual_takeM), combinational, same cycle.
- FSM states RUN and RECOVER.
  - RUN, mispredM=1:
    - flush_req=1 in the same cycle.
    - redirect_pc <= actual_takeM ? M.target : M.fallthru, registered.
    - redirect_valid <= 1 next cycle.
    - state <= RECOVER.
    - M.valid <= 0 next cycle.
  - RECOVER:
    - flush_req=1 and redirect_valid=1 held; redirect_pc stable.
    - No resolution (upd_en=0); E.valid and M.valid are forced 0.
    - On redirect_ready=1, redirect_valid <= 0 and state <= RUN next cycle.
  - redirect_ready sampled while RUN has no effect.
- Latency:
  - mispredict to flush_req: 0 cycles.
  - mispredict to redirect_valid: 1 cycle.
  - Minimum recovery: 2 cycles (RECOVER with ready=1 immediately).
- Counters: branch_cnt += resolveM; mispred_cnt += mispredM. Both wrap at 2^CNT_W.
- Simultaneous events:
  - flushE_ext with a resolving M branch: resolution is unaffected.
  - Mispredict while stallE: E is still cleared by flush_req.
- Reset:
  - state=RUN; all valid bits 0; counters 0.
  - redirect_valid=0, redirect_pc=0; upd_en, flush_req and mispredM are 0.
  - Reset in RECOVER aborts the pending redirect.

Decomposition:
- Package branch_pkg:
  - FSM state encoding (RUN=1'b0, RECOVER=1'b1).
  - Tracking-entry field widths and reset constants.
  - The two-bit counter state encodings shared with the predictor.
- Sub-module br_track_reg: one tracking entry with hold/flush/capture priority (flush > hold > capture), instantiated for E and M.

Test Plan:
- Correct prediction: branchD=1, pred_takeD=1, actual_takeM=1, no stalls → upd_en=1 exactly 2 cycles later with upd_pc=pcD; mispredM=0; branch_cnt=1, mispred_cnt=0.
- Taken mispredict: pred=0, actual=1, targetD=0x0040_0100 → flush_req same cycle; next cycle redirect_valid=1, redirect_pc=0x0040_0100; with ready=1, back to RUN after 1 cycle; mispred_cnt=1.
- Not-taken mispredict with backpressure:
  - Setup: pred=1, actual=0, fallthruD=0x0040_0008, redirect_ready=0 for 3 cycles.
  - Required: redirect_valid and flush_req held for 4 cycles; redirect_pc=0x0040_0008 stable; upd_en=0 during RECOVER.
- Stall: stallM=1 for 2 cycles while M holds a valid branch → upd_en=0 during the stall, then exactly one upd_en pulse on release; branch_cnt increments by 1.
- Back-to-back branches, both mispredicted, second in E during the first mispredict → second is flushed, never updates; branch_cnt=1.
- Reset asserted in RECOVER → next cycle redirect_valid=0, state RUN, counters 0; preload branch_cnt=2^32-1, then one branch → wraps to 0.
